hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller that drives the enable and flush inputs of the CPU's pipeline registers and PC register. It detects load-use hazards and taken-branch redirects. It also sequences a multi-cycle multiply in EX through a small state machine. The block sits beside the ID/EX stages and is the single source of every `*_en` and `*_flush` control in the pipeline.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register-file address width.
- `MUL_LAT`, 4, total cycles a multiply occupies EX; legal range 2..16.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction actually reads that source.
- `ex_rd`  in  REG_ADDR_W  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_is_mul`  in  1  the EX instruction is a multiply.
- `ex_branch_taken`  in  1  the EX branch or jump resolved as taken.
- `pc_en`, `ifid_en`, `idex_en`  out  1 each  register enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1 each  insert a bubble on the next clock.
- `mul_busy`  out  1  multiply sequencing is in progress.

## Operation
- All outputs are combinational from the current state and inputs; only the state and counter are registered.
- Defaults (no hazard): all `*_en` = 1, all `*_flush` = 0, `mul_busy` = 0.

State machine, states IDLE and BUSY, with a 4-bit counter `cnt`:
- In IDLE with `ex_is_mul`=1:
  - Assert the mul stall.
  - Next state BUSY, `cnt` = MUL_LAT-2.
- In BUSY with `cnt`≠0:
  - Assert the mul stall.
  - `cnt` decrements by 1.
- In BUSY with `cnt`=0 (release cycle):
  - Mul stall is not asserted.
  - Next state IDLE.
  - `ex_is_mul` is ignored in this cycle, so the same multiply does not retrigger.
- Mul stall outputs: `pc_en`=0, `ifid_en`=0, `idex_en`=0, `exmem_flush`=1, `mul_busy`=1.

Load-use hazard:
- Condition: `ex_mem_read` AND `ex_rd`≠0 AND ((`id_use_rs1` AND `id_rs1`==`ex_rd`) OR (`id_use_rs2` AND `id_rs2`==`ex_rd`)).
- Response: `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `idex_en`=1.

Taken branch:
- Condition: `ex_branch_taken`=1.
- Response: `ifid_flush`=1, `idex_flush`=1, `pc_en`=1.

Priority, highest first: mul stall, then taken branch, then load-use. Lower-priority responses are fully suppressed.

Register 0 never causes a hazard.

## Timing
- Load-use costs exactly 1 bubble. The following cycle the load has moved to MEM, so the condition clears.
- A multiply holds EX for MUL_LAT cycles and produces MUL_LAT-1 stall cycles.
  - With MUL_LAT=2, the first cycle stalls and the second cycle is the BUSY release cycle.
- Back-to-back multiplies: the second multiply enters EX the cycle after release, finds IDLE, and starts a new sequence.
- Reset value: state IDLE, `cnt`=0, so all outputs are at their defaults while reset is high.
- Reset asserted mid-BUSY aborts the sequence immediately and asynchronously; the stall drops in the same cycle.

## Configuration
- `HAZARD_STATS_EN` defined:
  - Adds output port `stall_cycles` (16 bits).
  - It increments on every clock where `pc_en`=0, and saturates at 16'hFFFF.
  - Reset clears it to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 for one cycle -> `pc_en`=0, `ifid_en`=0, `idex_flush`=1 that cycle only. Repeat with `ex_rd`=0 -> no stall.
- MUL_LAT=4, `ex_is_mul`=1 held 4 cycles -> `mul_busy`/`exmem_flush`=1 and `idex_en`=0 for 3 cycles, then all enables =1 on the 4th cycle; no retrigger.
- `ex_branch_taken`=1 together with a load-use match -> `ifid_flush`=`idex_flush`=1, `pc_en`=1.
- Two consecutive multiplies, MUL_LAT=2 -> stall pattern 1,0,1,0.
- Assert `reset` during the 2nd BUSY cycle -> outputs return to defaults asynchronously. After release, `ex_is_mul`=1 restarts a full MUL_LAT-1 stall.
- With `HAZARD_STATS_EN`, after one load-use stall plus one MUL_LAT=4 multiply -> `stall_cycles`=4.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline hazard controller: sole source of every *_en / *_flush control.
// Handles load-use stalls, taken-branch redirects and multi-cycle multiply
// sequencing in EX (IDLE/BUSY state machine with a down-counter).
// Optional build macro: HAZARD_STATS_EN adds a saturating 16-bit
// stall_cycles counter output that counts clocks with pc_en low.
module hazard_stall_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MUL_LAT    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_is_mul,
    input  logic                  ex_branch_taken,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  mul_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // BUSY starts at MUL_LAT-2 so that IDLE stall + BUSY countdown gives
    // MUL_LAT-1 stall cycles, followed by the cnt==0 release cycle.
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic       mul_stall;
    logic       load_use;
    logic       rs1_hit;
    logic       rs2_hit;

    // Multiply stall: a new multiply seen in IDLE, or countdown still running.
    // The release cycle (BUSY, cnt==0) ignores ex_is_mul so the same multiply
    // cannot retrigger.
    always_comb begin
        mul_stall = 1'b0;
        if (state == IDLE) begin
            mul_stall = ex_is_mul;
        end else begin
            mul_stall = (cnt != '0);
        end
    end

    // Load-use detection; register 0 never hazards.
    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

    // State register and countdown, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (ex_is_mul) begin
                    state_nx = BUSY;
                    cnt_nx   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output decode, priority: mul stall > taken branch > load-use.
    // Reset forces defaults so the stall drops the moment reset rises.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mul_busy    = 1'b0;
        if (!reset) begin
            if (mul_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
                mul_busy    = 1'b1;
            end else if (ex_branch_taken) begin
                pc_en      = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_en    = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating count of clocks on which the PC was held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: two instances (MUL_LAT=4 and
// MUL_LAT=2) share one stimulus stream; expected outputs are queued per
// cycle and compared at the falling edge.
module tb_hazard_stall_ctrl;

    localparam logic [6:0] DEF = 7'b1110000; // {pc,ifid,idex,ifid_f,idex_f,exmem_f,busy}
    localparam logic [6:0] LU  = 7'b0010100;
    localparam logic [6:0] BR  = 7'b1111100;
    localparam logic [6:0] MUL = 7'b0000011;

    typedef struct {
        logic [6:0] e4;
        logic [6:0] e2;
        string      nm;
    } exp_t;

    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mul;
        logic       br;
        logic [6:0] e4;
        logic [6:0] e2;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic ex_mem_read = 1'b0, ex_is_mul = 1'b0, ex_branch_taken = 1'b0;

    logic pc_en4, ifid_en4, idex_en4, ifid_flush4, idex_flush4, exmem_flush4, mul_busy4;
    logic pc_en2, ifid_en2, idex_en2, ifid_flush2, idex_flush2, exmem_flush2, mul_busy2;
`ifdef HAZARD_STATS_EN
    logic [15:0] sc4, sc2;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_ADDR_W(5), .MUL_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .exmem_flush(exmem_flush4),
        .mul_busy(mul_busy4)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(sc4)
`endif
    );

    hazard_stall_ctrl #(.REG_ADDR_W(5), .MUL_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2),
        .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .exmem_flush(exmem_flush2),
        .mul_busy(mul_busy2)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(sc2)
`endif
    );

    function automatic logic [6:0] get4();
        return {pc_en4, ifid_en4, idex_en4, ifid_flush4, idex_flush4, exmem_flush4, mul_busy4};
    endfunction

    function automatic logic [6:0] get2();
        return {pc_en2, ifid_en2, idex_en2, ifid_flush2, idex_flush2, exmem_flush2, mul_busy2};
    endfunction

    function automatic row_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic mul, input logic br,
                                input logic [6:0] e4, input logic [6:0] e2);
        row_t r;
        r.mr = mr; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.mul = mul; r.br = br; r.e4 = e4; r.e2 = e2;
        return r;
    endfunction

    // Drive one cycle of inputs just after the rising edge, queue the
    // expectation, and return at the falling edge ready for comparison.
    task automatic apply(input row_t r, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        ex_mem_read = r.mr; ex_rd = r.rd; id_rs1 = r.rs1; id_rs2 = r.rs2;
        id_use_rs1 = r.u1; id_use_rs2 = r.u2; ex_is_mul = r.mul; ex_branch_taken = r.br;
        x.e4 = r.e4; x.e2 = r.e2; x.nm = nm;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t x;
        x.e4 = DEF; x.e2 = DEF; x.nm = "reset_defaults";
        sb.push_back(x);
        @(negedge clk);
        x = sb.pop_front();
        checks++;
        if (get4() !== x.e4) begin
            errors++;
            $display("FAIL %s lat4 got %b expected %b", x.nm, get4(), x.e4);
        end
        checks++;
        if (get2() !== x.e2) begin
            errors++;
            $display("FAIL %s lat2 got %b expected %b", x.nm, get2(), x.e2);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (sc4 !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats got %0d expected 0", sc4);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        row_t r[$];
        exp_t x;
        r.push_back(mk(1, 5,  3,  5, 1, 1, 0, 0, LU,  LU));
        r.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, DEF, DEF));
        r.push_back(mk(1, 0,  0,  0, 1, 1, 0, 0, DEF, DEF));
        r.push_back(mk(1, 7,  7,  2, 0, 1, 0, 0, DEF, DEF));
        r.push_back(mk(1, 7,  7,  2, 1, 0, 0, 0, LU,  LU));
        r.push_back(mk(0, 7,  7,  7, 1, 1, 0, 0, DEF, DEF));
        r.push_back(mk(1, 31, 31, 0, 1, 0, 0, 0, LU,  LU));
        r.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, DEF, DEF));
        foreach (r[i]) begin
            apply(r[i], $sformatf("load_use_%0d", i));
            x = sb.pop_front();
            checks++;
            if (get4() !== x.e4) begin
                errors++;
                $display("FAIL %s lat4 got %b expected %b", x.nm, get4(), x.e4);
            end
            checks++;
            if (get2() !== x.e2) begin
                errors++;
                $display("FAIL %s lat2 got %b expected %b", x.nm, get2(), x.e2);
            end
        end
    endtask

    task automatic test_branch();
        row_t r[$];
        exp_t x;
        r.push_back(mk(1, 5, 5, 0, 1, 0, 0, 1, BR,  BR));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, BR,  BR));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF));
        foreach (r[i]) begin
            apply(r[i], $sformatf("branch_%0d", i));
            x = sb.pop_front();
            checks++;
            if (get4() !== x.e4) begin
                errors++;
                $display("FAIL %s lat4 got %b expected %b", x.nm, get4(), x.e4);
            end
            checks++;
            if (get2() !== x.e2) begin
                errors++;
                $display("FAIL %s lat2 got %b expected %b", x.nm, get2(), x.e2);
            end
        end
    endtask

    // ex_is_mul held 4 cycles: lat4 stalls 3 then releases with no retrigger;
    // lat2 sees back-to-back multiplies (1,0,1,0).
    task automatic test_back_to_back();
        row_t r[$];
        exp_t x;
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MUL, MUL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MUL, DEF));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MUL, MUL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, DEF, DEF));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF));
        foreach (r[i]) begin
            apply(r[i], $sformatf("mul_seq_%0d", i));
            x = sb.pop_front();
            checks++;
            if (get4() !== x.e4) begin
                errors++;
                $display("FAIL %s lat4 got %b expected %b", x.nm, get4(), x.e4);
            end
            checks++;
            if (get2() !== x.e2) begin
                errors++;
                $display("FAIL %s lat2 got %b expected %b", x.nm, get2(), x.e2);
            end
        end
    endtask

    task automatic test_priority();
        row_t r[$];
        exp_t x;
        r.push_back(mk(1, 5, 5, 0, 1, 0, 1, 1, MUL, MUL));
        r.push_back(mk(1, 5, 5, 0, 1, 0, 0, 1, MUL, BR));
        r.push_back(mk(1, 5, 5, 0, 1, 0, 0, 1, MUL, BR));
        r.push_back(mk(1, 5, 5, 0, 1, 0, 0, 1, BR,  BR));
        r.push_back(mk(1, 5, 5, 0, 1, 0, 0, 0, LU,  LU));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF));
        foreach (r[i]) begin
            apply(r[i], $sformatf("priority_%0d", i));
            x = sb.pop_front();
            checks++;
            if (get4() !== x.e4) begin
                errors++;
                $display("FAIL %s lat4 got %b expected %b", x.nm, get4(), x.e4);
            end
            checks++;
            if (get2() !== x.e2) begin
                errors++;
                $display("FAIL %s lat2 got %b expected %b", x.nm, get2(), x.e2);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        row_t r[$];
        exp_t x;
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MUL, MUL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MUL, DEF));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, MUL, DEF));
        foreach (r[i]) begin
            apply(r[i], $sformatf("pre_reset_%0d", i));
            x = sb.pop_front();
            checks++;
            if (get4() !== x.e4) begin
                errors++;
                $display("FAIL %s lat4 got %b expected %b", x.nm, get4(), x.e4);
            end
            checks++;
            if (get2() !== x.e2) begin
                errors++;
                $display("FAIL %s lat2 got %b expected %b", x.nm, get2(), x.e2);
            end
        end
        // Mid-cycle asynchronous reset during the second BUSY cycle.
        #1;
        reset = 1'b1;
        x.e4 = DEF; x.e2 = DEF; x.nm = "async_reset";
        sb.push_back(x);
        #1;
        x = sb.pop_front();
        checks++;
        if (get4() !== x.e4) begin
            errors++;
            $display("FAIL %s lat4 got %b expected %b", x.nm, get4(), x.e4);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        r.delete();
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MUL, MUL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MUL, DEF));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MUL, MUL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, DEF, DEF));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF));
        foreach (r[i]) begin
            apply(r[i], $sformatf("post_reset_%0d", i));
            x = sb.pop_front();
            checks++;
            if (get4() !== x.e4) begin
                errors++;
                $display("FAIL %s lat4 got %b expected %b", x.nm, get4(), x.e4);
            end
            checks++;
            if (get2() !== x.e2) begin
                errors++;
                $display("FAIL %s lat2 got %b expected %b", x.nm, get2(), x.e2);
            end
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        row_t r[$];
        exp_t x;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r.push_back(mk(1, 5, 0, 5, 0, 1, 0, 0, LU,  LU));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MUL, MUL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, MUL, DEF));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, MUL, DEF));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF));
        foreach (r[i]) begin
            apply(r[i], $sformatf("stats_%0d", i));
            x = sb.pop_front();
            checks++;
            if (get4() !== x.e4) begin
                errors++;
                $display("FAIL %s lat4 got %b expected %b", x.nm, get4(), x.e4);
            end
        end
        checks++;
        if (sc4 !== 16'd4) begin
            errors++;
            $display("FAIL stall_cycles lat4 got %0d expected 4", sc4);
        end
        checks++;
        if (sc2 !== 16'd2) begin
            errors++;
            $display("FAIL stall_cycles lat2 got %0d expected 2", sc2);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_priority();
        test_reset_mid_busy();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
